pattern_match_ack_ctrl: RTL and testbench

//  Downstream consumer of PatternDetection2. Watches found_pattern, drives the detector's ack

---
 rtl/pattern_match_ack_ctrl_if.sv | 28 ++
 rtl/pattern_match_ack_ctrl.sv | 142 ++++++++++++++
 tb/tb_pattern_match_ack_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_match_ack_ctrl_if.sv
// Detector/readout signal bundle for pattern_match_ack_ctrl.
// The master side drives stream, clear and pop controls; the slave side returns ack and FIFO/status.
interface pattern_match_ack_ctrl_if #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 16
);
  logic             data_valid;
  logic             found_pattern;
  logic             ack;
  logic             clear;
  logic             rd_en;
  logic [IDX_W-1:0] rd_data;
  logic             empty;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] match_count;
  logic             err_timeout;

  modport master (
    output data_valid, found_pattern, clear, rd_en,
    input  ack, rd_data, empty, full, overflow, match_count, err_timeout
  );

  modport slave (
    input  data_valid, found_pattern, clear, rd_en,
    output ack, rd_data, empty, full, overflow, match_count, err_timeout
  );
endinterface

// File: rtl/pattern_match_ack_ctrl.sv
// Acks detector matches, counts them and logs match positions in a FWFT FIFO; ack is registered.
// Optional ack-low watchdog enabled by defining PMAC_TIMEOUT_EN.
module pattern_match_ack_ctrl #(
  parameter int IDX_W          = 8,
  parameter int CNT_W          = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int ACK_LOW_CYCLES = 2,
  parameter int TIMEOUT        = 16
) (
  input  logic                   clk,
  input  logic                   reset_sync,
  pattern_match_ack_ctrl_if.slave bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LC_MAX = (TIMEOUT > ACK_LOW_CYCLES) ? TIMEOUT : ACK_LOW_CYCLES;
  localparam int LC_W   = $clog2(LC_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACK_LO, RECOVER} state_t;

  state_t           state;
  logic [LC_W-1:0]  lowcnt;
  logic             ack_q;
  logic [IDX_W-1:0] byte_idx;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             ovf;
  logic             push;
  logic             pop;
  logic             accept;
  logic             fifo_empty;
  logic             fifo_full;
  logic             low_done;
  logic             wd_fire;

  assign push       = (state == IDLE) && bus.found_pattern;
  assign low_done   = lowcnt >= LC_W'(ACK_LOW_CYCLES - 1);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = bus.rd_en && !fifo_empty;
  // A same-cycle pop frees the slot, so a push on full is still taken.
  assign accept     = push && (!fifo_full || pop);

`ifdef PMAC_TIMEOUT_EN
  assign wd_fire = (state == ACK_LO) && bus.found_pattern && (lowcnt >= LC_W'(TIMEOUT - 1));
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      lowcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b1;
          if (bus.found_pattern) begin
            state  <= ACK_LO;
            ack_q  <= 1'b0;
            lowcnt <= '0;
          end
        end
        ACK_LO: begin
          if ((low_done && !bus.found_pattern) || wd_fire) begin
            state <= RECOVER;
            ack_q <= 1'b1;
          end else if (lowcnt != LC_W'(LC_MAX)) begin
            lowcnt <= lowcnt + 1'b1;
          end
        end
        RECOVER: begin
          state <= IDLE;
          ack_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ack_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      byte_idx <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
    end else if (bus.clear) begin
      byte_idx <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
    end else begin
      if (bus.data_valid && ack_q && !bus.found_pattern)
        byte_idx <= byte_idx + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (push && !accept)
        ovf <= 1'b1;
      if (push && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.clear && accept)
      mem[wr_ptr[PTR_W-1:0]] <= byte_idx;
  end

`ifdef PMAC_TIMEOUT_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync)
      err_q <= 1'b0;
    else if (bus.clear)
      err_q <= 1'b0;
    else if (wd_fire)
      err_q <= 1'b1;
  end
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.ack         = ack_q;
  assign bus.rd_data     = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
  assign bus.empty       = fifo_empty;
  assign bus.full        = fifo_full;
  assign bus.overflow    = ovf;
  assign bus.match_count = cnt;

endmodule

// File: tb/tb_pattern_match_ack_ctrl.sv
// Directed and randomized bench for pattern_match_ack_ctrl against a queue-based reference model.
module tb_pattern_match_ack_ctrl;
  localparam int IDX_W = 8;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;
  localparam int ACK_LOW = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_sync;

  pattern_match_ack_ctrl_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) pif ();

  pattern_match_ack_ctrl #(
    .IDX_W(IDX_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH),
    .ACK_LOW_CYCLES(ACK_LOW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_sync(reset_sync),
    .bus(pif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: handshake tracked as "busy for m_low cycles" plus a pending recovery cycle.
  int  m_idx, m_cnt, m_low;
  bit  m_ack, m_busy, m_rec, m_ovf, m_err;
  int  q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_low = 0;
    m_ack = 0; m_busy = 0; m_rec = 0; m_ovf = 0; m_err = 0;
    q.delete();
  endtask

  task automatic model_edge(input bit dv, input bit fp, input bit clr, input bit rd);
    bit push, pop, inc;
    push = 0;
    pop  = rd && (q.size() > 0);
    inc  = dv && m_ack && !fp;
    if (m_rec) begin
      m_rec = 0;
    end else if (!m_busy) begin
      if (fp) begin
        push = 1; m_busy = 1; m_low = 1;
      end
    end else begin
      if (m_low >= ACK_LOW && !fp) begin
        m_busy = 0; m_rec = 1;
      end
`ifdef PMAC_TIMEOUT_EN
      else if (fp && m_low >= TIMEOUT) begin
        m_busy = 0; m_rec = 1; m_err = 1;
      end
`endif
      else m_low++;
    end
    m_ack = !m_busy;
    if (clr) begin
      m_idx = 0; m_cnt = 0; m_ovf = 0; m_err = 0;
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (q.size() < DEPTH) q.push_back(m_idx);
        else m_ovf = 1;
      end
      if (inc) m_idx = (m_idx + 1) % (1 << IDX_W);
    end
  endtask

  task automatic compare_all();
    check_eq("ack", pif.ack, m_ack);
    check_eq("empty", pif.empty, q.size() == 0);
    check_eq("full", pif.full, q.size() == DEPTH);
    check_eq("overflow", pif.overflow, m_ovf);
    check_eq("match_count", pif.match_count, m_cnt);
    check_eq("rd_data", pif.rd_data, (q.size() > 0) ? q[0] : 0);
    check_eq("err_timeout", pif.err_timeout, m_err);
  endtask

  task automatic step(input bit dv, input bit fp, input bit clr, input bit rd);
    pif.data_valid = dv; pif.found_pattern = fp; pif.clear = clr; pif.rd_en = rd;
    @(posedge clk);
    model_edge(dv, fp, clr, rd);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset_sync = 1'b0;
    pif.data_valid = 0; pif.found_pattern = 0; pif.clear = 0; pif.rd_en = 0;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(negedge clk);
    compare_all();
    reset_sync = 1'b1;
  endtask

  // One full handshake: match edge, two low cycles, recovery, back in idle.
  task automatic do_match(input bit rd);
    step(0, 1, 0, rd);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    bit fp_r;
    reset_sync = 1'b0;
    pif.data_valid = 0; pif.found_pattern = 0; pif.clear = 0; pif.rd_en = 0;

    // Reset and first edge after release
    do_reset();
    check_eq("reset_ack", pif.ack, 0);
    check_eq("reset_empty", pif.empty, 1);
    check_eq("reset_count", pif.match_count, 0);
    step(0, 0, 0, 0);
    check_eq("ack_after_release", pif.ack, 1);

    // Single match after five bytes
    repeat (5) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check_eq("ack_low_1", pif.ack, 0);
    step(1, 0, 0, 0);
    check_eq("ack_low_2", pif.ack, 0);
    step(1, 0, 0, 0);
    check_eq("recover_ack", pif.ack, 1);
    step(1, 1, 0, 0);
    check_eq("recover_no_double", pif.match_count, 1);
    check_eq("first_pos", pif.rd_data, 5);
    step(1, 0, 0, 0);
    do_match(1);
    check_eq("second_pos", pif.rd_data, 6);

    // Five matches, no reads: overflow
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      do_match(0);
    end
    check_eq("fill_full", pif.full, 1);
    check_eq("fill_ovf", pif.overflow, 1);
    check_eq("fill_count", pif.match_count, 5);
    for (int i = 1; i <= 4; i++) begin
      check_eq("pop_order", pif.rd_data, i);
      step(0, 0, 0, 1);
    end
    check_eq("drained_empty", pif.empty, 1);
    step(0, 0, 0, 1);
    check_eq("underflow_rd_data", pif.rd_data, 0);

    // Push and pop on a full FIFO
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      do_match(0);
    end
    step(1, 0, 0, 0);
    do_match(1);
    check_eq("pushpop_ovf", pif.overflow, 0);
    check_eq("pushpop_full", pif.full, 1);
    check_eq("pushpop_head", pif.rd_data, 2);

    // Stuck found_pattern
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    repeat (15) step(0, 1, 0, 0);
    check_eq("wd_not_yet", pif.err_timeout, 0);
    step(0, 1, 0, 0);
`ifdef PMAC_TIMEOUT_EN
    check_eq("wd_err", pif.err_timeout, 1);
    check_eq("wd_ack", pif.ack, 1);
`else
    check_eq("no_wd_err", pif.err_timeout, 0);
    check_eq("no_wd_ack", pif.ack, 0);
`endif
    repeat (4) step(0, 0, 0, 0);
    check_eq("stuck_released_ack", pif.ack, 1);

    // Clear during the low phase
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      do_match(0);
    end
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check_eq("clear_count", pif.match_count, 0);
    check_eq("clear_empty", pif.empty, 1);
    check_eq("clear_ack_held", pif.ack, 0);
    repeat (3) step(0, 0, 0, 0);
    check_eq("clear_handshake_done", pif.ack, 1);

    // Randomized traffic with a detector-like found_pattern
    fp_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!fp_r && m_ack && ($urandom_range(0, 3) == 0)) fp_r = 1;
      else if (fp_r && !m_ack && ($urandom_range(0, 1) == 0)) fp_r = 0;
      step(($urandom_range(0, 3) != 0), fp_r, ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0));
    end

    // Reset in the middle of a handshake
    step(0, 1, 0, 0);
    do_reset();
    check_eq("midreset_ack", pif.ack, 0);
    check_eq("midreset_empty", pif.empty, 1);
    step(0, 0, 0, 0);
    check_eq("midreset_recover", pif.ack, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
